fp_norm_pack: RTL and testbench

- Multi-cycle normalise-and-pack stage of the single-precision FP adder.
- Sits after the aligned mantissa add/subtract. Takes the sign, the tentative exponent and the 25-bit raw mantissa sum, then normalises iteratively.
- Emits the packed IEEE-754 word as {sign, exp, mant}, with done/busy handshaking.

---
 rtl/fp_norm_pkg.sv | 19 +
 rtl/fp_norm_pack_lzc8.sv | 15 +
 rtl/fp_norm_pack.sv | 130 +++++++++++++
 tb/tb_fp_norm_pack.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// rtl/fp_norm_pkg.sv - shared types and constants for the FP normalise-and-pack stage
package fp_norm_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef enum logic {
    IDLE,
    NORM
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } fp32_t;

endpackage

// File: rtl/fp_norm_pack_lzc8.sv
// rtl/fp_norm_pack_lzc8.sv - 8-bit leading-zero counter (8 when the input is all zeros)
module lzc8 (
  input  logic [7:0] data,
  output logic [3:0] count
);

  // Later (higher) bits overwrite earlier ones, so the most significant one wins.
  always_comb begin
    count = 4'd8;
    for (int i = 0; i < 8; i++) begin
      if (data[i]) count = 4'(7 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// rtl/fp_norm_pack.sv - iterative normalise-and-pack stage of the FP adder
// Optional multi-bit left shift per cycle when FP_NORM_FAST_SHIFT_EN is defined.
module fp_norm_pack
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             _go,
  input  logic             sign,
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W+1:0] mant,
  output logic             busy,
  output logic             done,
  output logic [31:0]      out
);

  localparam logic [EXP_W:0] ONE   = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] INF_W = {1'b0, EXP_INF};

  state_t         state_q, state_d;
  logic           sign_q, sign_d;
  logic [EXP_W:0] exp_q, exp_d;
  logic [MAN_W+1:0] mant_q, mant_d;
  fp32_t          out_q, out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           finish;
  logic [EXP_W:0] exp_inc;
  logic [EXP_W:0] shamt;

  assign exp_inc = exp_q + ONE;

`ifdef FP_NORM_FAST_SHIFT_EN
  logic [3:0]     lz;
  logic [EXP_W:0] exp_m1;

  lzc8 u_lzc8 (
    .data  (mant_q[MAN_W:MAN_W-7]),
    .count (lz)
  );

  // Cap at exp-1 so a long shift never passes the subnormal floor.
  assign exp_m1 = exp_q - ONE;
  always_comb begin
    shamt = {{(EXP_W-3){1'b0}}, lz};
    if (exp_m1 < shamt) shamt = exp_m1;
  end
`else
  assign shamt = ONE;
`endif

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (_go) begin
          state_d = NORM;
          busy_d  = 1'b1;
          sign_d  = sign;
          mant_d  = mant;
          exp_d   = {1'b0, exp};
          if (exp == '0 && mant[MAN_W]) exp_d = ONE;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          out_d  = {sign_q, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
          finish = 1'b1;
        end else if (mant_q[MAN_W+1]) begin
          mant_d = mant_q >> 1;
          exp_d  = exp_inc;
          if (exp_inc == INF_W) begin
            out_d  = {sign_q, EXP_INF, {MAN_W{1'b0}}};
            finish = 1'b1;
          end
        end else if (mant_q[MAN_W]) begin
          out_d  = {sign_q, exp_q[EXP_W-1:0], mant_q[MAN_W-1:0]};
          finish = 1'b1;
        end else if (exp_q <= ONE) begin
          out_d  = {sign_q, {EXP_W{1'b0}}, mant_q[MAN_W-1:0]};
          finish = 1'b1;
        end else begin
          mant_d = mant_q << shamt;
          exp_d  = exp_q - shamt;
        end
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_fp_norm_pack.sv
// tb/tb_fp_norm_pack.sv - directed table-driven bench for fp_norm_pack
module tb_fp_norm_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        sign;
  logic [7:0]  exp;
  logic [24:0] mant;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic [31:0] res;
    int          cyc;
  } vec_t;

  vec_t vt[12];

  always #5 clk = ~clk;

  fp_norm_pack dut (
    .clk   (clk),
    .reset (reset),
    ._go   (go),
    .sign  (sign),
    .exp   (exp),
    .mant  (mant),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_lat(input string name, input int act, input int req);
    n_vec++;
`ifdef FP_NORM_FAST_SHIFT_EN
    if (act > req) begin
`else
    if (act != req) begin
`endif
      n_miss++;
      $display("FAIL %s: done in cycle %0d, expected %0d", name, act, req);
    end
  endtask

  // Cycle 1 is the cycle after the edge that samples go.
  task automatic run_op(input bit b2b, input logic s, input logic [7:0] e, input logic [24:0] m,
                        output int cyc, output logic busy1, output bit timeout);
    if (!b2b) @(negedge clk);
    go = 1'b1; sign = s; exp = e; mant = m;
    @(posedge clk); #1;
    go = 1'b0;
    busy1 = busy;
    cyc = 1;
    timeout = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  int          cyc;
  logic        b1;
  bit          to;
  int          pulses;
  logic [31:0] held;

  initial begin
    vt[0]  = '{1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 2};
    vt[1]  = '{1'b0, 8'h7F, 25'h1800000, 32'h40400000, 3};
    vt[2]  = '{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 25};
    vt[3]  = '{1'b1, 8'h7F, 25'h0000000, 32'h80000000, 2};
    vt[4]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 2};
    vt[5]  = '{1'b0, 8'h02, 25'h0100000, 32'h00200000, 3};
    vt[6]  = '{1'b1, 8'h00, 25'h0800000, 32'h80800000, 2};
    vt[7]  = '{1'b0, 8'h00, 25'h0400000, 32'h00400000, 2};
    vt[8]  = '{1'b1, 8'h81, 25'h0C00000, 32'hC0C00000, 2};
    vt[9]  = '{1'b0, 8'h85, 25'h0030000, 32'h3FC00000, 8};
    vt[10] = '{1'b0, 8'h7F, 25'h1FFFFFF, 32'h407FFFFF, 3};
    vt[11] = '{1'b0, 8'h04, 25'h0000100, 32'h00000800, 5};

    reset = 1'b1; go = 1'b0; sign = 1'b0; exp = '0; mant = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_out", out, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, vt[i].s, vt[i].e, vt[i].m, cyc, b1, to);
      check($sformatf("v%0d_timeout", i), {31'b0, to}, 32'd0);
      check($sformatf("v%0d_busy", i), {31'b0, b1}, 32'd1);
      check($sformatf("v%0d_out", i), out, vt[i].res);
      check_lat($sformatf("v%0d_latency", i), cyc, vt[i].cyc);
      @(posedge clk); #1;
      check($sformatf("v%0d_idle", i), {30'b0, busy, done}, 32'd0);
    end

    // go while busy must not disturb the running operation
    @(negedge clk);
    go = 1'b1; sign = 1'b0; exp = 8'h7F; mant = 25'h0000001;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    go = 1'b1; sign = 1'b1; exp = 8'h10; mant = 25'h0800000;
    @(posedge clk); #1;
    go = 1'b0;
    cyc = 3; to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin to = 1'b0; break; end
    end
    check("busy_go_timeout", {31'b0, to}, 32'd0);
    check("busy_go_out", out, 32'h34000000);
    check_lat("busy_go_latency", cyc, 25);
    repeat (3) @(posedge clk);
    #1;
    check("busy_go_no_second", {30'b0, busy, done}, 32'd0);
    check("busy_go_held", out, 32'h34000000);

    // reset mid-NORM aborts with no done
    @(negedge clk);
    go = 1'b1; sign = 1'b0; exp = 8'h7F; mant = 25'h0000001;
    @(posedge clk); #1;
    go = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_out", out, 32'h0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // back-to-back: second go in the cycle done is high
    run_op(1'b0, 1'b0, 8'h7F, 25'h0800000, cyc, b1, to);
    check("b2b_a_out", out, 32'h3F800000);
    held = out;
    check("b2b_a_done", {31'b0, done}, 32'd1);
    run_op(1'b1, 1'b0, 8'h7F, 25'h1800000, cyc, b1, to);
    check("b2b_b_accepted", {31'b0, b1}, 32'd1);
    check("b2b_b_timeout", {31'b0, to}, 32'd0);
    check("b2b_b_out", out, 32'h40400000);
    check_lat("b2b_b_latency", cyc, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
